// File: rtl/io_enter_ctrl_pkg.sv
// io_pkg: shared types and constants for the board I/O front-end.
//   io_ctrl_state_t : handshake FSM states
//   io_mode_t       : transaction kind latched when a request is accepted
//   IO_DEBOUNCE_CYCLES : default key debounce length, also used by the display block
package io_pkg;

  typedef enum logic [2:0] {
    IO_IDLE         = 3'd0,
    IO_WAIT_PRESS   = 3'd1,
    IO_WAIT_RELEASE = 3'd2,
    IO_DONE         = 3'd3,
    IO_HALTED       = 3'd4
  } io_ctrl_state_t;

  typedef enum logic {
    IO_MODE_IN  = 1'b0,
    IO_MODE_OUT = 1'b1
  } io_mode_t;

  // 10 ms at 50 MHz
  localparam int unsigned IO_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/io_enter_ctrl_if.sv
// io_enter_ctrl_if: handshake between the MIPS core and the I/O controller.
//   in_req, out_req, halt : core -> controller request levels
//   stall, waiting        : controller -> core / status display
//   in_data, data_valid   : controller -> register-file write path
// modport master is the core side, modport slave the controller side.
interface io_enter_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_req;
  logic                  out_req;
  logic                  halt;
  logic                  stall;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  data_valid;
  logic                  waiting;

  modport master (
    output in_req, out_req, halt,
    input  stall, in_data, data_valid, waiting
  );

  modport slave (
    input  in_req, out_req, halt,
    output stall, in_data, data_valid, waiting
  );
endinterface

// File: rtl/io_enter_ctrl_key_debounce.sv
// key_debounce: conditions a raw, bouncing, active-low push-button.
//   clk, reset      : system clock, asynchronous active-high reset
//   key_n_i         : raw key level, asynchronous to clk
//   key_stable_o    : debounced level (1 = released)
//   press_evt_o     : one-cycle pulse when key_stable_o falls
//   release_evt_o   : one-cycle pulse when key_stable_o rises
// A new level is accepted after the synchronized input has differed from
// the accepted level for DEBOUNCE_CYCLES consecutive cycles.
module key_debounce
  import io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic key_stable_o,
  output logic press_evt_o,
  output logic release_evt_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_comb begin
    cnt_d     = '0;
    stable_d  = stable_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d  = sync2_q;
        press_d   = ~sync2_q;
        release_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Reset treats the key as released, so a key held through reset only
  // produces a press after a full debounce interval.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      stable_q  <= 1'b1;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= key_n_i;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_stable_o  = stable_q;
  assign press_evt_o   = press_q;
  assign release_evt_o = release_q;

endmodule

// File: rtl/io_enter_ctrl.sv
// io_enter_ctrl: Enter-key conditioning and IN/OUT operator handshake.
//   clk, reset : system clock, asynchronous active-high reset
//   enter_n    : raw Enter key, active-low, bouncing, asynchronous
//   sw         : raw slide switches, sampled on the accepted press of an IN
//   bus        : slave side of io_enter_ctrl_if (requests in; stall,
//                waiting, in_data, data_valid out)
// The core is stalled from the cycle after a request is accepted until the
// key has been pressed and released; a request dropped mid-way aborts
// silently. After completion the FSM waits for both requests to fall so a
// still-held request cannot start a second transaction. halt parks the FSM
// until reset.
module io_enter_ctrl
  import io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES,
  parameter int unsigned SW_WIDTH        = 10,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enter_n,
  input  logic [SW_WIDTH-1:0] sw,
  io_enter_ctrl_if.slave      bus
);

  logic key_level;
  logic press_evt;
  logic release_evt;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk          (clk),
    .reset        (reset),
    .key_n_i      (enter_n),
    .key_stable_o (key_level),
    .press_evt_o  (press_evt),
    .release_evt_o(release_evt)
  );

  io_ctrl_state_t        state_q, state_d;
  io_mode_t              mode_q, mode_d;
  logic [DATA_WIDTH-1:0] in_data_q, in_data_d;
  logic                  stall_q, waiting_q, data_valid_q;
  logic                  req_held;

  // The request that opened the transaction must stay up; the other one is
  // irrelevant once a mode is latched.
  assign req_held = (mode_q == IO_MODE_IN) ? bus.in_req : bus.out_req;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    in_data_d = in_data_q;
    unique case (state_q)
      IO_IDLE: begin
        // Both requests high is illegal and ignored.
        if (bus.in_req ^ bus.out_req) begin
          state_d = IO_WAIT_PRESS;
          mode_d  = bus.in_req ? IO_MODE_IN : IO_MODE_OUT;
        end
      end
      IO_WAIT_PRESS: begin
        if (!req_held) begin
          state_d = IO_IDLE;
        end else if (press_evt && !key_level) begin
          // Only a fresh press edge counts; a key held on entry never
          // generates one until it has been released.
          state_d = IO_WAIT_RELEASE;
          if (mode_q == IO_MODE_IN) begin
            in_data_d = DATA_WIDTH'(sw);
          end
        end
      end
      IO_WAIT_RELEASE: begin
        if (!req_held) begin
          state_d = IO_IDLE;
        end else if (release_evt) begin
          state_d = IO_DONE;
        end
      end
      IO_DONE: begin
        if (!bus.in_req && !bus.out_req) begin
          state_d = IO_IDLE;
        end
      end
      IO_HALTED: begin
        state_d = IO_HALTED;
      end
      default: begin
        state_d = IO_IDLE;
      end
    endcase

    // halt overrides everything, including a press sampled this cycle.
    if (bus.halt) begin
      state_d   = IO_HALTED;
      in_data_d = in_data_q;
    end
  end

  // Outputs are decoded from the next state and registered, so they change
  // on the same edge as the state and are glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IO_IDLE;
      mode_q       <= IO_MODE_IN;
      in_data_q    <= '0;
      stall_q      <= 1'b0;
      waiting_q    <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      in_data_q    <= in_data_d;
      stall_q      <= (state_d == IO_WAIT_PRESS) || (state_d == IO_WAIT_RELEASE);
      waiting_q    <= (state_d == IO_WAIT_PRESS);
      data_valid_q <= (state_d == IO_DONE) && (state_q != IO_DONE);
    end
  end

  assign bus.stall      = stall_q;
  assign bus.waiting    = waiting_q;
  assign bus.data_valid = data_valid_q;
  assign bus.in_data    = in_data_q;

endmodule

// File: tb/tb_io_enter_ctrl.sv
module tb_io_enter_ctrl;

  localparam int DC = 4;

  logic       clk;
  logic       reset;
  logic       enter_n;
  logic [9:0] sw;

  io_enter_ctrl_if #(.DATA_WIDTH(32)) bus ();

  io_enter_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .SW_WIDTH       (10),
    .DATA_WIDTH     (32)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enter_n(enter_n),
    .sw     (sw),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 50)
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Key conditioning: the raw key reaches the comparison stage two samples
  // late; the accepted level flips once the last DC delayed samples all
  // disagree with it. Handshake: a transaction is a sequence of
  // accept -> press -> release, with abort on request drop.
  bit          m_d1, m_d2, m_stable, m_press, m_release;
  bit          m_win [DC];
  bit          m_active, m_mode_in, m_pressed, m_done_hold, m_halted, m_dv;
  logic [31:0] m_data;

  task automatic model_reset();
    m_d1 = 1; m_d2 = 1; m_stable = 1; m_press = 0; m_release = 0;
    for (int i = 0; i < DC; i++) m_win[i] = 1;
    m_active = 0; m_mode_in = 0; m_pressed = 0; m_done_hold = 0;
    m_halted = 0; m_dv = 0; m_data = '0;
  endtask

  task automatic model_edge();
    bit req, all_mis, was_press, was_release;
    was_press   = m_press;
    was_release = m_release;
    m_dv = 0;
    if (m_halted) begin
    end else if (bus.halt) begin
      m_halted = 1; m_active = 0; m_done_hold = 0;
    end else if (m_done_hold) begin
      if (!bus.in_req && !bus.out_req) m_done_hold = 0;
    end else if (m_active) begin
      req = m_mode_in ? bus.in_req : bus.out_req;
      if (!req) m_active = 0;
      else if (!m_pressed) begin
        if (was_press) begin
          m_pressed = 1;
          if (m_mode_in) m_data = {22'd0, sw};
        end
      end else if (was_release) begin
        m_active = 0; m_done_hold = 1; m_dv = 1;
      end
    end else if (bus.in_req != bus.out_req) begin
      m_active = 1; m_mode_in = bus.in_req; m_pressed = 0;
    end
    for (int i = 0; i < DC - 1; i++) m_win[i] = m_win[i+1];
    m_win[DC-1] = m_d2;
    all_mis = 1;
    for (int i = 0; i < DC; i++) if (m_win[i] == m_stable) all_mis = 0;
    m_press = 0; m_release = 0;
    if (all_mis) begin
      m_stable  = !m_stable;
      m_press   = !m_stable;
      m_release = m_stable;
    end
    m_d2 = m_d1;
    m_d1 = enter_n;
  endtask

  task automatic check_all();
    chk("stall",      {31'd0, bus.stall},      {31'd0, m_active});
    chk("waiting",    {31'd0, bus.waiting},    {31'd0, m_active && !m_pressed});
    chk("data_valid", {31'd0, bus.data_valid}, {31'd0, m_dv});
    chk("in_data",    bus.in_data,             m_data);
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    check_all();
  endtask

  // Called at posedge+1; reset is released on the following negedge.
  task automatic pulse_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Key held through reset: the press is seen 2 + DC edges after release.
  task automatic probe_press();
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("press_evt_after_reset", {31'd0, dut.u_debounce.press_evt_o}, {31'd0, k == 2 + DC});
      chk("no_stall_after_reset", {31'd0, bus.stall}, 32'd0);
    end
    $display("[TB] reset-release with key held: press_evt probed over 8 cycles");
  endtask

  typedef struct {
    bit          in_req, out_req, halt, enter_n;
    logic [9:0]  sw;
    int          cyc;
    bit          e_stall, e_wait;
    logic [31:0] e_data;
    int          e_dv;
  } row_t;

  row_t rows [18];

  initial begin
    int dv_cnt, press_cnt, hold, txn;

    rows[0]  = '{0,0,0,1, 10'h000,  3, 0,0, 32'h000, 0};
    rows[1]  = '{1,0,0,1, 10'h2A5,  1, 1,1, 32'h000, 0};
    rows[2]  = '{1,0,0,0, 10'h2A5, 20, 1,0, 32'h2A5, 0};
    rows[3]  = '{1,0,0,1, 10'h2A5, 20, 0,0, 32'h2A5, 1};
    rows[4]  = '{1,0,0,1, 10'h000, 10, 0,0, 32'h2A5, 0};
    rows[5]  = '{0,0,0,1, 10'h000,  2, 0,0, 32'h2A5, 0};
    rows[6]  = '{0,1,0,1, 10'h155,  1, 1,1, 32'h2A5, 0};
    rows[7]  = '{0,1,0,0, 10'h155, 12, 1,0, 32'h2A5, 0};
    rows[8]  = '{0,1,0,1, 10'h155, 12, 0,0, 32'h2A5, 1};
    rows[9]  = '{0,0,0,1, 10'h000,  2, 0,0, 32'h2A5, 0};
    rows[10] = '{1,1,0,1, 10'h000,  4, 0,0, 32'h2A5, 0};
    rows[11] = '{1,0,0,1, 10'h3FF,  1, 1,1, 32'h2A5, 0};
    rows[12] = '{1,0,0,0, 10'h3FF, 12, 1,0, 32'h3FF, 0};
    rows[13] = '{0,0,0,0, 10'h3FF,  1, 0,0, 32'h3FF, 0};
    rows[14] = '{0,0,0,1, 10'h000, 12, 0,0, 32'h3FF, 0};
    rows[15] = '{1,0,1,1, 10'h000,  1, 0,0, 32'h3FF, 0};
    rows[16] = '{1,0,0,0, 10'h123, 12, 0,0, 32'h3FF, 0};
    rows[17] = '{1,0,0,1, 10'h123, 12, 0,0, 32'h3FF, 0};

    // ---- reset with key held ----
    reset = 1'b1; enter_n = 1'b0; sw = '0;
    bus.in_req = 0; bus.out_req = 0; bus.halt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall",      {31'd0, bus.stall},      32'd0);
    chk("reset_waiting",    {31'd0, bus.waiting},    32'd0);
    chk("reset_data_valid", {31'd0, bus.data_valid}, 32'd0);
    chk("reset_in_data",    bus.in_data,             32'd0);
    @(negedge clk);
    reset = 1'b0;
    probe_press();
    enter_n = 1'b1;
    repeat (10) step();

    // ---- table-driven handshake scenarios ----
    for (int r = 0; r < 18; r++) begin
      bus.in_req = rows[r].in_req; bus.out_req = rows[r].out_req;
      bus.halt = rows[r].halt; enter_n = rows[r].enter_n; sw = rows[r].sw;
      dv_cnt = 0;
      for (int c = 0; c < rows[r].cyc; c++) begin
        step();
        if (bus.data_valid) dv_cnt++;
      end
      chk($sformatf("row%0d_stall", r),   {31'd0, bus.stall},   {31'd0, rows[r].e_stall});
      chk($sformatf("row%0d_waiting", r), {31'd0, bus.waiting}, {31'd0, rows[r].e_wait});
      chk($sformatf("row%0d_in_data", r), bus.in_data,          rows[r].e_data);
      chk($sformatf("row%0d_dv_count", r), dv_cnt,              rows[r].e_dv);
      $display("[TB] row %0d: in=%0b out=%0b halt=%0b enter_n=%0b x%0d -> stall=%0b in_data=%h dv=%0d",
               r, rows[r].in_req, rows[r].out_req, rows[r].halt, rows[r].enter_n,
               rows[r].cyc, bus.stall, bus.in_data, dv_cnt);
    end

    // ---- bounce rejection in WAIT_PRESS ----
    bus.halt = 0; bus.in_req = 0; enter_n = 1'b1;
    pulse_reset();
    bus.in_req = 1; sw = 10'h0F0;
    step();
    press_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      enter_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      step();
      if (dut.u_debounce.press_evt_o) press_cnt++;
    end
    chk("bounce_no_press_while_toggling", press_cnt, 0);
    chk("bounce_still_waiting", {31'd0, bus.waiting}, 32'd1);
    enter_n = 1'b0;
    press_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (dut.u_debounce.press_evt_o) press_cnt++;
    end
    chk("bounce_one_press", press_cnt, 1);
    chk("bounce_in_data", bus.in_data, 32'h0F0);
    chk("bounce_stalled", {31'd0, bus.stall}, 32'd1);
    $display("[TB] bounce: one press accepted, in_data=%h", bus.in_data);

    // ---- asynchronous reset mid-transaction, key still held ----
    #1;
    reset = 1'b1;
    bus.in_req = 0;
    model_reset();
    #1;
    chk("async_reset_stall", {31'd0, bus.stall}, 32'd0);
    chk("async_reset_in_data", bus.in_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    probe_press();
    enter_n = 1'b1;
    repeat (10) step();

    // ---- randomized traffic against the model ----
    hold = 0; txn = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) pulse_reset();
      if ($urandom_range(0, 19) == 0) bus.in_req = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) bus.out_req = 1'($urandom_range(0, 1));
      bus.halt = ($urandom_range(0, 599) == 0);
      if (hold == 0) begin
        enter_n = ~enter_n;
        hold = $urandom_range(1, 10);
      end else begin
        hold--;
      end
      sw = 10'($urandom);
      step();
      if (m_dv) begin
        txn++;
        $display("[TB] random txn %0d: mode=%s in_data=%h", txn, m_mode_in ? "IN" : "OUT", bus.in_data);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
